// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DZ   = 2'd3
  } md_state_e;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the mul/div datapath: a radix-2 Booth step or a restoring
// division step, selected by op_i.
//
// Work register layout (2*WIDTH+1 bits):
//   MULT: {A[WIDTH-1:0], Q[WIDTH-1:0], q_-1}
//   DIV : {R[WIDTH:0],   Q[WIDTH-1:0]}
module md_iter_step
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic               op_i,
  input  logic [2*WIDTH:0]   work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH:0]   work_o
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] d_ext;

  // Booth add/sub is done one bit wider than A so that A-M with the most
  // negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    a_ext = {work_i[2*WIDTH], work_i[2*WIDTH:WIDTH+1]};
    m_ext = {opnd_i[WIDTH-1], opnd_i};
    unique case (work_i[1:0])
      2'b01:   sum = a_ext + m_ext;
      2'b10:   sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase

    r_sh  = {work_i[2*WIDTH-1:WIDTH], work_i[WIDTH-1]};
    d_ext = {1'b0, opnd_i};

    work_o = work_i;
    if (op_i == MD_MULT) begin
      work_o = {sum, work_i[WIDTH:1]};
    end else if (r_sh >= d_ext) begin
      work_o = {r_sh - d_ext, work_i[WIDTH-2:0], 1'b1};
    end else begin
      work_o = {r_sh, work_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multicycle multiply/divide sequencer: accepts a MULT/DIV request in IDLE,
// iterates WIDTH cycles, then presents registered HI/LO with a write strobe.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH:0]   step_work;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  md_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i   (op_q),
    .work_i (work_q),
    .opnd_i (opnd_q),
    .work_o (step_work)
  );

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag = src_a[WIDTH-1] ? ('0 - src_a) : src_a;
    b_mag = src_b[WIDTH-1] ? ('0 - src_b) : src_b;
    quo   = step_work[WIDTH-1:0];
    rem   = step_work[2*WIDTH-1:WIDTH];
  end

  // Next-state, counter, operand load and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op == MD_DIV && src_b == '0) begin
            state_d = DZ;
          end else begin
            op_d   = op;
            qneg_d = src_a[WIDTH-1] ^ src_b[WIDTH-1];
            rneg_d = src_a[WIDTH-1];
            cnt_d  = '0;
            if (op == MD_DIV) begin
              opnd_d = b_mag;
              work_d = {{(WIDTH+1){1'b0}}, a_mag};
            end else begin
              opnd_d = src_a;
              work_d = {{WIDTH{1'b0}}, src_b, 1'b0};
            end
            state_d = RUN;
          end
        end
      end
      RUN: begin
        work_d = step_work;
        cnt_d  = cnt_q + CNT_W'(1);
        // The last step and sign correction land in HI/LO on the FIN entry edge.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
          if (op_q == MD_DIV) begin
            lo_d = qneg_q ? ('0 - quo) : quo;
            hi_d = rneg_q ? ('0 - rem) : rem;
          end else begin
            hi_d = step_work[2*WIDTH:WIDTH+1];
            lo_d = step_work[WIDTH:1];
          end
        end
      end
      FIN:     state_d = IDLE;
      DZ:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      opnd_q  <= '0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign hilo_write = (state_q == FIN);
  assign div0       = (state_q == DZ);
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div0, hilo_write;
  logic [31:0] hi_out, lo_out;

  md_sequencer #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .div0       (div0),
    .hilo_write (hilo_write),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          r_done_k, r_done_cnt, r_hw_k, r_hw_cnt;
  int          r_div0_k, r_div0_cnt, r_busy_cnt;
  logic        busy_v [0:40];
  logic [31:0] r_hi, r_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clock);
    chk("idle", 64'(busy), 64'(0));
    @(negedge clock);
  endtask

  // Issue one request and observe 40 cycles after the accepting edge.
  // With hold set, start stays high and operands keep changing.
  task automatic run_op(input logic opv, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    r_done_k = 0; r_done_cnt = 0; r_hw_k = 0; r_hw_cnt = 0;
    r_div0_k = 0; r_div0_cnt = 0; r_busy_cnt = 0;
    r_hi = '0; r_lo = '0;
    @(negedge clock);
    start = 1'b1; op = opv; src_a = a; src_b = b;
    @(posedge clock);
    #1;
    if (!hold) begin
      start = 1'b0; op = ~opv; src_a = ~a; src_b = $urandom;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      busy_v[k] = busy;
      if (busy) r_busy_cnt++;
      if (done) begin
        r_done_cnt++;
        if (r_done_k == 0) begin
          r_done_k = k; r_hi = hi_out; r_lo = lo_out;
        end
      end
      if (hilo_write) begin
        r_hw_cnt++;
        if (r_hw_k == 0) r_hw_k = k;
      end
      if (div0) begin
        r_div0_cnt++;
        if (r_div0_k == 0) r_div0_k = k;
      end
      if (hold) begin
        op = 1'($urandom); src_a = $urandom; src_b = $urandom | 32'h1;
      end
    end
    start = 1'b0;
    wait_idle();
  endtask

  task automatic chk_res(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
    chk({tag, "_done"}, 64'(r_done_cnt), 64'(1));
    chk({tag, "_hi"}, 64'(r_hi), 64'(hi_e));
    chk({tag, "_lo"}, 64'(r_lo), 64'(lo_e));
  endtask

  initial begin
    int cnt_d, cnt_w;
    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div0", 64'(div0), 64'(0));
    chk("rst_hw",   64'(hilo_write), 64'(0));
    chk("rst_hi",   64'(hi_out), 64'(0));
    chk("rst_lo",   64'(lo_out), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // MULT 7 x -3 with latency checks
    run_op(MD_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    chk_res("mul7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    chk("mul_busy_cycles", 64'(r_busy_cnt), 64'(33));
    chk("mul_done_edge",   64'(r_done_k - 1), 64'(32));
    chk("mul_hw_edge",     64'(r_hw_k - 1), 64'(32));
    chk("mul_hw_cnt",      64'(r_hw_cnt), 64'(1));
    chk("mul_div0_cnt",    64'(r_div0_cnt), 64'(0));

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk_res("div-7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk_res("divmin/-1", 32'h0000_0000, 32'h8000_0000);
    chk("divmin_div0_cnt", 64'(r_div0_cnt), 64'(0));
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk_res("mulmin2", 32'h4000_0000, 32'h0000_0000);
    run_op(MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    chk_res("mulmaxmin", 32'hC000_0000, 32'h8000_0000);
    run_op(MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    chk_res("div7/-2", 32'h0000_0001, 32'hFFFF_FFFD);

    // HI/LO = 1/2, then divide by zero must leave them alone
    run_op(MD_DIV, 32'h0000_0005, 32'h0000_0002, 1'b0);
    chk_res("div5/2", 32'h0000_0001, 32'h0000_0002);
    run_op(MD_DIV, 32'h0000_0005, 32'h0000_0000, 1'b0);
    chk("dz_div0_k",   64'(r_div0_k), 64'(1));
    chk("dz_div0_cnt", 64'(r_div0_cnt), 64'(1));
    chk("dz_hw_cnt",   64'(r_hw_cnt), 64'(0));
    chk("dz_done_cnt", 64'(r_done_cnt), 64'(0));
    chk("dz_busy_k1",  64'(busy_v[1]), 64'(1));
    chk("dz_busy_k2",  64'(busy_v[2]), 64'(0));
    chk("dz_hi",       64'(hi_out), 64'(1));
    chk("dz_lo",       64'(lo_out), 64'(2));

    // start held high with changing operands
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk_res("hold_m1xm1", 32'h0000_0000, 32'h0000_0001);
    chk("hold_fin_k33",  64'(busy_v[33]), 64'(1));
    chk("hold_idle_k34", 64'(busy_v[34]), 64'(0));
    chk("hold_acc_k35",  64'(busy_v[35]), 64'(1));

    run_op(MD_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b0);
    chk_res("div-8/-3", 32'hFFFF_FFFE, 32'h0000_0002);

    // Reset mid-DIV clears outputs asynchronously and aborts the operation
    @(negedge clock);
    start = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_div0", 64'(div0), 64'(0));
    chk("arst_hw",   64'(hilo_write), 64'(0));
    chk("arst_hi",   64'(hi_out), 64'(0));
    chk("arst_lo",   64'(lo_out), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    cnt_d = 0; cnt_w = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) cnt_d++;
      if (hilo_write) cnt_w++;
    end
    chk("arst_no_done", 64'(cnt_d), 64'(0));
    chk("arst_no_hw",   64'(cnt_w), 64'(0));

    run_op(MD_MULT, 32'd3, 32'd4, 1'b0);
    chk_res("mul3x4", 32'h0000_0000, 32'h0000_000C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
